// File: rtl/r_burst_arbiter.sv
// rtl/r_burst_arbiter.sv - burst-granular round-robin merge of NUM_SRC R-channel streams
module r_burst_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int MAX_BEATS  = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]      src_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data,
    input  logic [NUM_SRC*RESP_WIDTH-1:0]    src_resp,
    input  logic [NUM_SRC-1:0]               src_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ID_WIDTH-1:0]              out_id,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [RESP_WIDTH-1:0]            out_resp,
    output logic                             out_last,
    output logic [$clog2(NUM_SRC > 1 ? NUM_SRC : 2)-1:0] grant_idx,
    output logic                             busy,
    output logic                             burst_err,
    input  logic                             err_clr
);
    localparam int IDX_W = $clog2(NUM_SRC > 1 ? NUM_SRC : 2);
    localparam int CNT_W = $clog2(MAX_BEATS);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [IDX_W-1:0] LAST_SRC  = IDX_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

    logic [0:0]            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_q;
    logic [CNT_W-1:0]      beat_cnt;

    logic                  found;
    logic                  found_hi;
    logic                  found_lo;
    logic [IDX_W-1:0]      pick_hi;
    logic [IDX_W-1:0]      pick_lo;
    logic [IDX_W-1:0]      pick;
    logic [IDX_W-1:0]      rr_next;

    logic                  sel_valid;
    logic                  sel_last;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [RESP_WIDTH-1:0] sel_resp;

    logic                  xfer;
    logic                  at_limit;
    logic                  release_burst;
    logic                  err_set;

    // Rotating priority as two passes: sources at/above rr_ptr win, else lowest valid overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && !found_hi && (IDX_W'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                pick_hi  = IDX_W'(i);
            end
            if (src_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = IDX_W'(i);
            end
        end
        found = found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_id    = '0;
        sel_data  = '0;
        sel_resp  = '0;
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_id    = src_id[i*ID_WIDTH +: ID_WIDTH];
                sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_resp  = src_resp[i*RESP_WIDTH +: RESP_WIDTH];
                src_ready[i] = busy & out_ready;
            end
        end
    end

    assign busy      = (state == S_BURST);
    assign grant_idx = grant_q;
    assign out_valid = busy & sel_valid;
    assign out_last  = busy & sel_last;
    assign out_id    = busy ? sel_id   : '0;
    assign out_data  = busy ? sel_data : '0;
    assign out_resp  = busy ? sel_resp : '0;

    assign xfer          = out_valid & out_ready;
    assign at_limit      = (beat_cnt == CNT_LIMIT);
    assign release_burst = xfer & (out_last | at_limit);
    assign err_set       = xfer & ~out_last & at_limit;
    assign rr_next       = (grant_q == LAST_SRC) ? '0 : grant_q + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                if (found) begin
                    grant_q  <= pick;
                    beat_cnt <= '0;
                    state    <= S_BURST;
                end
            end else if (release_burst) begin
                state  <= S_IDLE;
                rr_ptr <= rr_next;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            if (err_set) begin
                burst_err <= 1'b1;
            end else if (err_clr) begin
                burst_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_r_burst_arbiter.sv
// tb/tb_r_burst_arbiter.sv - directed and randomized checks of r_burst_arbiter against a burst-level model
module tb_r_burst_arbiter;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int RW = 2;
    localparam int MB = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*IW-1:0] src_id;
    logic [N*DW-1:0] src_data;
    logic [N*RW-1:0] src_resp;
    logic [N-1:0]    src_last;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_id;
    logic [DW-1:0]   out_data;
    logic [RW-1:0]   out_resp;
    logic            out_last;
    logic [GW-1:0]   grant_idx;
    logic            busy;
    logic            burst_err;
    logic            err_clr;

    r_burst_arbiter #(
        .NUM_SRC(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .MAX_BEATS(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready), .src_id(src_id),
        .src_data(src_data), .src_resp(src_resp), .src_last(src_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_data(out_data), .out_resp(out_resp), .out_last(out_last),
        .grant_idx(grant_idx), .busy(busy), .burst_err(burst_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner of the current burst (-1 when free), next preferred source, beats moved so far.
    int m_owner;
    int m_gq;
    int m_ptr;
    int m_beats;
    bit m_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gq    = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_check();
        logic [N-1:0] exp_ready;
        exp_ready = '0;
        if (m_owner < 0) begin
            check_eq("out_valid", 64'(out_valid), 64'd0);
            check_eq("out_id",    64'(out_id),    64'd0);
            check_eq("out_data",  64'(out_data),  64'd0);
            check_eq("out_resp",  64'(out_resp),  64'd0);
            check_eq("out_last",  64'(out_last),  64'd0);
        end else begin
            exp_ready[m_owner] = out_ready;
            check_eq("out_valid", 64'(out_valid), 64'(src_valid[m_owner]));
            check_eq("out_id",    64'(out_id),    64'(src_id[m_owner*IW +: IW]));
            check_eq("out_data",  64'(out_data),  64'(src_data[m_owner*DW +: DW]));
            check_eq("out_resp",  64'(out_resp),  64'(src_resp[m_owner*RW +: RW]));
            check_eq("out_last",  64'(out_last),  64'(src_last[m_owner]));
        end
        check_eq("src_ready", 64'(src_ready), 64'(exp_ready));
        check_eq("grant_idx", 64'(grant_idx), 64'(m_gq));
        check_eq("busy",      64'(busy),      64'(m_owner >= 0));
        check_eq("burst_err", 64'(burst_err), 64'(m_err));
    endtask

    task automatic model_advance();
        bit set_err;
        set_err = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && src_valid[c]) begin
                    m_owner = c;
                    m_gq    = c;
                    m_beats = 0;
                end
            end
        end else if (src_valid[m_owner] && out_ready) begin
            m_beats++;
            if (src_last[m_owner] || m_beats == MB) begin
                set_err = !src_last[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        if (set_err)
            m_err = 1'b1;
        else if (err_clr)
            m_err = 1'b0;
    endtask

    // Inputs are changed just after a falling edge; outputs are checked 1ns later.
    task automatic step(output logic [N-1:0] hs);
        #1;
        if (rst) model_reset();
        model_check();
        hs = src_valid & src_ready;
        if (!rst) model_advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        src_valid = '0;
        src_last  = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
    endtask

    task automatic set_src(input int s, input logic [IW-1:0] id, input logic [DW-1:0] d, input logic last);
        src_valid[s]           = 1'b1;
        src_last[s]            = last;
        src_id[s*IW +: IW]     = id;
        src_data[s*DW +: DW]   = d;
        src_resp[s*RW +: RW]   = RW'(s);
    endtask

    task automatic do_reset();
        logic [N-1:0] hs;
        idle_inputs();
        rst = 1'b1;
        step(hs);
        step(hs);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] hs;
        int xfers;
        int beat;
        int sent[N];
        int order[$];

        src_id   = '0;
        src_data = '0;
        src_resp = '0;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_src_ready", 64'(src_ready), 64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_grant",     64'(grant_idx), 64'd0);
        check_eq("rst_err",       64'(burst_err), 64'd0);
        step(hs);

        // single source, 4-beat burst from source 2
        do_reset();
        set_src(2, 4'hA, 32'h200, 1'b0);
        #1 check_eq("t30_idle_busy", 64'(busy), 64'd0);
        step(hs);
        for (int b = 1; b <= 4; b++) begin
            set_src(2, 4'hA, 32'h200 + 32'(b), b == 4);
            #1;
            check_eq("t30_busy",  64'(busy),      64'd1);
            check_eq("t30_valid", 64'(out_valid), 64'd1);
            check_eq("t30_id",    64'(out_id),    64'hA);
            check_eq("t30_data",  64'(out_data),  64'h200 + 64'(b));
            step(hs);
        end
        idle_inputs();
        #1 check_eq("t30_done_busy", 64'(busy), 64'd0);
        step(hs);
        for (int s = 0; s < N; s++) set_src(s, IW'(s), DW'(s), 1'b1);
        step(hs);
        #1 check_eq("t30_next_grant", 64'(grant_idx), 64'd3);
        step(hs);
        idle_inputs();
        step(hs);

        // fairness with all sources continuously valid, 2-beat bursts
        do_reset();
        for (int s = 0; s < N; s++) sent[s] = 0;
        order.delete();
        for (int cyc = 0; cyc < 15; cyc++) begin
            idle_inputs();
            for (int s = 0; s < N; s++) set_src(s, IW'(s), DW'(cyc), (sent[s] % 2) == 1);
            #1;
            check_eq("t31_busy", 64'(busy), 64'((cyc % 3) != 0));
            if (cyc % 3 == 1) order.push_back(int'(grant_idx));
            step(hs);
            for (int s = 0; s < N; s++) if (hs[s]) sent[s]++;
        end
        check_eq("t31_order_len", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check_eq("t31_order", 64'(order[i]), 64'(i % 4));

        // backpressure during a 3-beat burst of source 1
        do_reset();
        xfers = 0;
        beat  = 0;
        for (int cyc = 0; cyc < 12 && beat < 3; cyc++) begin
            idle_inputs();
            out_ready = (cyc % 2) == 1;
            set_src(1, 4'h5, 32'h1000 + 32'(beat), beat == 2);
            #1;
            if (busy) begin
                check_eq("t32_ready", 64'(src_ready), 64'(out_ready) << 1);
                check_eq("t32_data",  64'(out_data),  64'h1000 + 64'(beat));
            end
            if (out_valid && out_ready) xfers++;
            step(hs);
            if (hs[1]) beat++;
        end
        idle_inputs();
        #1;
        check_eq("t32_xfers", 64'(xfers), 64'd3);
        check_eq("t32_busy",  64'(busy),  64'd0);
        step(hs);

        // overlong burst is cut after MAX_BEATS transfers
        do_reset();
        set_src(0, 4'h1, 32'h300, 1'b0);
        step(hs);
        for (int b = 0; b < 4; b++) begin
            set_src(0, 4'h1, 32'h300 + 32'(b), 1'b0);
            step(hs);
        end
        #1;
        check_eq("t33_err",  64'(burst_err), 64'd1);
        check_eq("t33_busy", 64'(busy),      64'd0);
        set_src(1, 4'h2, 32'h400, 1'b1);
        step(hs);
        #1 check_eq("t33_grant", 64'(grant_idx), 64'd1);
        err_clr = 1'b1;
        step(hs);
        idle_inputs();
        #1 check_eq("t33_err_clr", 64'(burst_err), 64'd0);
        step(hs);

        // pointer at 3, only source 1 valid
        do_reset();
        set_src(2, 4'h3, 32'h33, 1'b1);
        step(hs);
        step(hs);
        idle_inputs();
        set_src(1, 4'h7, 32'h55, 1'b1);
        step(hs);
        #1 check_eq("t34_grant", 64'(grant_idx), 64'd1);
        step(hs);
        for (int s = 0; s < N; s++) set_src(s, IW'(s), DW'(s), 1'b1);
        step(hs);
        #1 check_eq("t34_next_grant", 64'(grant_idx), 64'd2);
        step(hs);

        // reset in the middle of a burst from source 3
        do_reset();
        set_src(3, 4'h9, 32'h900, 1'b0);
        step(hs);
        step(hs);
        set_src(3, 4'h9, 32'h901, 1'b0);
        #1 check_eq("t35_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("t35_valid", 64'(out_valid), 64'd0);
        check_eq("t35_busy",  64'(busy),      64'd0);
        check_eq("t35_grant", 64'(grant_idx), 64'd0);
        check_eq("t35_err",   64'(burst_err), 64'd0);
        step(hs);
        idle_inputs();
        step(hs);

        // randomized traffic
        do_reset();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            src_valid = N'($urandom);
            src_resp  = (N*RW)'($urandom);
            src_id    = (N*IW)'($urandom);
            for (int s = 0; s < N; s++) begin
                src_data[s*DW +: DW] = DW'($urandom);
                src_last[s]          = $urandom_range(3) == 0;
            end
            out_ready = $urandom_range(3) != 0;
            err_clr   = $urandom_range(15) == 0;
            rst       = $urandom_range(199) == 0;
            step(hs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/r_burst_arbiter.md
R_BURST_ARBITER -- requirements
Module: r_burst_arbiter

Interface
REQ-001 SHALL have parameters: NUM_SRC, default 4, number of R sources (2..8, power of two not required); ID_WIDTH, default 4; DATA_WIDTH, default 64; RESP_WIDTH, default 2; MAX_BEATS, default 256, beat limit per burst (>=2).
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port src_valid  input  NUM_SRC  per-source beat valid.
REQ-005 SHALL have port src_ready  output  NUM_SRC  per-source beat accept.
REQ-006 SHALL have port src_id  input  NUM_SRC*ID_WIDTH  per-source ID; source i occupies slice [i*ID_WIDTH +: ID_WIDTH].
REQ-007 SHALL have port src_data  input  NUM_SRC*DATA_WIDTH  per-source data, same slicing.
REQ-008 SHALL have port src_resp  input  NUM_SRC*RESP_WIDTH  per-source RESP, same slicing.
REQ-009 SHALL have port src_last  input  NUM_SRC  per-source LAST.
REQ-010 SHALL have ports out_valid  output  1, out_ready  input  1, out_id  output  ID_WIDTH, out_data  output  DATA_WIDTH, out_resp  output  RESP_WIDTH, out_last  output  1: merged R stream toward the ordering unit.
REQ-011 SHALL have port grant_idx  output  max(1,$clog2(NUM_SRC))  index of currently owning source.
REQ-012 SHALL have port busy  output  1  high while a burst is owned (BURST state).
REQ-013 SHALL have port burst_err  output  1  sticky: burst exceeded MAX_BEATS without LAST.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of burst_err.

Function
REQ-015 SHALL implement FSM with states IDLE and BURST; grant held for a whole burst (no interleaving of beats from different sources).
REQ-016 IDLE: if any src_valid, SHALL select first asserted source searching from rr_ptr upward with wrap NUM_SRC-1 -> 0, register it into grant_q, clear beat_cnt, go to BURST next cycle; if none valid, stay IDLE.
REQ-017 IDLE: out_valid=0, src_ready all 0, out_id/out_data/out_resp/out_last = 0.
REQ-018 BURST: out_valid/id/data/resp/last SHALL equal source grant_q inputs combinationally; src_ready[grant_q]=out_ready; all other src_ready=0.
REQ-019 Beat transfer = out_valid & out_ready; no other event advances state or counters.
REQ-020 On transfer with out_last=1: SHALL go to IDLE, rr_ptr <= (grant_q+1) mod NUM_SRC (explicit wrap for non-power-of-two).
REQ-021 On transfer with out_last=0: beat_cnt increments; if beat_cnt == MAX_BEATS-1 before increment, SHALL set burst_err, go to IDLE, advance rr_ptr as REQ-020 (forced release).
REQ-022 beat_cnt width $clog2(MAX_BEATS); never wraps (REQ-021 releases first).
REQ-023 Arbitration latency: first beat of a granted burst presented exactly 1 cycle after IDLE decision; one idle cycle between consecutive bursts.
REQ-024 Grant decision in IDLE SHALL be independent of out_ready.
REQ-025 burst_err: set has priority over err_clr in same cycle; otherwise err_clr=1 clears it.
REQ-026 grant_idx = grant_q at all times; busy = (state==BURST).
REQ-027 Source dropping src_valid mid-burst SHALL NOT release grant; out_valid simply follows it low.

Reset
REQ-028 On rst: state IDLE, rr_ptr 0, grant_q 0, beat_cnt 0, burst_err 0; hence out_valid 0, src_ready all 0, busy 0, grant_idx 0, out fields 0.
REQ-029 rst asserted mid-burst SHALL abandon the burst immediately; no beat transfers while rst high.

Verification
REQ-030 Single source: src 2 sends 4-beat burst (last on beat 4), out_ready=1 -> busy 1 cycle after request, 4 consecutive output beats with id/data of src 2, then IDLE, rr_ptr=3.
REQ-031 Fairness: all 4 sources continuously valid with 2-beat bursts from reset -> grant order 0,1,2,3,0; no beat interleaving; one idle cycle between bursts.
REQ-032 Backpressure: out_ready toggles 1/0 during 3-beat burst of src 1 -> src_ready[1] mirrors out_ready, others 0, data held stable, exactly 3 transfers.
REQ-033 Overlong burst: MAX_BEATS=4, src 0 sends 6 beats last=0 -> after 4th transfer burst_err=1, FSM IDLE, rr_ptr=1; err_clr pulse -> burst_err=0.
REQ-034 Wrap/skip: rr_ptr=3, only src 1 valid -> grant_idx=1; after burst rr_ptr=2.
REQ-035 Reset mid-burst: rst during beat 2 of src 3 -> next cycle out_valid 0, busy 0, grant_idx 0, burst_err 0.
